fetch_unit: RTL

- Instruction-fetch stage directly upstream of the controller/decoder.
- Owns the program counter and the instruction register.
- On the controller's load_ir pulse, it fetches one 32-bit word from instruction memory through a req/ready handshake and latches it into the IR. The decoder then slices the IR into opcode/cond/rn/rd/rm/rs.
- Also executes the controller's load_pc (branch target) and clear_pc requests.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/fetch_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage and its neighbours.
//   fetch_state_t : fetch-unit controller states
//   NOP_INSTR     : instruction-register contents meaning "no operation"
//   PC_WIDTH      : program counter / address width
//   align_word    : forces an address onto a 32-bit word boundary
package cpu_pkg;

    typedef enum logic [1:0] {
        F_IDLE  = 2'd0,
        F_WAIT  = 2'd1,
        F_FAULT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam int          PC_WIDTH  = 32;

    function automatic logic [PC_WIDTH-1:0] align_word(input logic [PC_WIDTH-1:0] a);
        return {a[PC_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the PC and the instruction register, fetches
// one word from instruction memory per load_ir via a req/ready handshake and
// carries out branch (load_pc) and clear (clear_pc) requests.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   load_ir          fetch the next instruction
//   load_pc, pc_in   load word-aligned pc_in into the PC
//   clear_pc         load RESET_PC into the PC (wins over load_pc)
//   imem_rdata/ready instruction memory response
//   imem_req/addr    registered read request, address == pc_out
//   pc_out           current PC
//   instr, instr_pc  instruction register and the address it came from
//   instr_valid      one-cycle pulse after instr was updated
//   busy             fetch outstanding
//   fetch_fault      sticky fetch timeout, cleared only by clear_pc or reset
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4,
    parameter int          MAX_WAIT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_ir,
    input  logic                load_pc,
    input  logic                clear_pc,
    input  logic [PC_WIDTH-1:0] pc_in,
    input  logic [31:0]         imem_rdata,
    input  logic                imem_ready,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic [31:0]         instr,
    output logic [PC_WIDTH-1:0] instr_pc,
    output logic                instr_valid,
    output logic                busy,
    output logic                fetch_fault
);

    localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

    fetch_state_t        r_state;
    fetch_state_t        w_next_state;

    logic [PC_WIDTH-1:0] r_pc;
    logic [31:0]         r_instr;
    logic [PC_WIDTH-1:0] r_instr_pc;
    logic                r_instr_valid;
    logic                r_req;
    logic                r_busy;
    logic                r_fault;
    logic [7:0]          r_wait_cnt;
    logic                r_pend_vld;
    logic [PC_WIDTH-1:0] r_pend_pc;

    logic                w_fetch_done;
    logic                w_fault_entry;
    logic                w_upd_req;
    logic [PC_WIDTH-1:0] w_upd_pc;
    logic [7:0]          w_cnt_inc;
    logic                w_unused_ok;

    // The two low bits of a branch target are discarded by alignment.
    assign w_unused_ok = ^pc_in[1:0];

    // A PC request this cycle, resolved with clear_pc taking priority.
    assign w_upd_req = clear_pc | load_pc;
    assign w_upd_pc  = clear_pc ? RESET_PC : align_word(pc_in);
    assign w_cnt_inc = r_wait_cnt + 8'd1;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= F_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and completion/timeout strobes
    always_comb begin
        w_next_state  = r_state;
        w_fetch_done  = 1'b0;
        w_fault_entry = 1'b0;
        case (r_state)
            F_IDLE: begin
                if (load_ir) begin
                    w_next_state = F_WAIT;
                end
            end
            F_WAIT: begin
                if (r_req && imem_ready) begin
                    w_fetch_done = 1'b1;
                    w_next_state = F_IDLE;
                end else if (w_cnt_inc == LP_MAX_WAIT) begin
                    w_fault_entry = 1'b1;
                    w_next_state  = F_FAULT;
                end
            end
            F_FAULT: begin
                if (clear_pc) begin
                    w_next_state = F_IDLE;
                end
            end
            default: begin
                w_next_state = F_IDLE;
            end
        endcase
    end

    // Datapath: PC, IR, pending update, wait counter, registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_instr       <= NOP_INSTR;
            r_instr_pc    <= RESET_PC;
            r_instr_valid <= 1'b0;
            r_req         <= 1'b0;
            r_busy        <= 1'b0;
            r_fault       <= 1'b0;
            r_wait_cnt    <= 8'd0;
            r_pend_vld    <= 1'b0;
            r_pend_pc     <= RESET_PC;
        end else begin
            // Status outputs are registered copies of the upcoming state, so
            // they line up with the state the unit is actually in.
            r_instr_valid <= w_fetch_done;
            r_req         <= (w_next_state == F_WAIT);
            r_busy        <= (w_next_state == F_WAIT);
            r_fault       <= (w_next_state == F_FAULT);

            case (r_state)
                F_IDLE: begin
                    // The PC moves on the same edge WAIT is entered, so a
                    // coincident load_ir fetches from the new address.
                    if (w_upd_req) begin
                        r_pc <= w_upd_pc;
                    end
                    r_wait_cnt <= 8'd0;
                    r_pend_vld <= 1'b0;
                end
                F_WAIT: begin
                    if (w_fetch_done) begin
                        r_instr    <= imem_rdata;
                        r_instr_pc <= r_pc;
                        // Latest request wins, including one arriving on the
                        // completion cycle itself.
                        if (w_upd_req) begin
                            r_pc <= w_upd_pc;
                        end else if (r_pend_vld) begin
                            r_pc <= r_pend_pc;
                        end else begin
                            r_pc <= r_pc + PC_STEP;
                        end
                        r_pend_vld <= 1'b0;
                    end else if (w_fault_entry) begin
                        r_instr    <= NOP_INSTR;
                        r_wait_cnt <= w_cnt_inc;
                        r_pend_vld <= 1'b0;
                    end else begin
                        r_wait_cnt <= w_cnt_inc;
                        if (w_upd_req) begin
                            r_pend_vld <= 1'b1;
                            r_pend_pc  <= w_upd_pc;
                        end
                    end
                end
                F_FAULT: begin
                    if (clear_pc) begin
                        r_pc <= RESET_PC;
                    end
                end
                default: begin
                    r_wait_cnt <= 8'd0;
                    r_pend_vld <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign pc_out      = r_pc;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;
    assign busy        = r_busy;
    assign fetch_fault = r_fault;

endmodule
